// File: rtl/host_irq_ctrl_pkg.sv
// host_irq_ctrl_pkg: register map, widths and the priority encoder shared by
// the interrupt aggregator, its bus interface and its testbench.
package host_irq_ctrl_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int MAX_SRC = 16;

  localparam logic [ADDR_W-1:0] ADDR_PENDING = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_VECTOR  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_HOLDOFF = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_FORCE   = 3'd6;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } prio_t;

  // Lowest set bit wins (source 0 is the highest priority).
  function automatic prio_t prio_encode(input logic [MAX_SRC-1:0] vec);
    prio_t res;
    res.valid = 1'b0;
    res.idx   = 4'd0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.valid = 1'b1;
        res.idx   = 4'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/host_irq_ctrl_if.sv
// host_irq_ctrl_if: Avalon-MM slave register port of the interrupt aggregator.
interface host_irq_ctrl_if;
  import host_irq_ctrl_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/host_irq_sync.sv
// host_irq_sync: per-source synchroniser chain plus one delay flop used for
// rising-edge detection. SYNC_STAGES=0 bypasses the chain for same-clock sources.
module host_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic irq_i,
  output logic s_o,
  output logic rise_o
);

  logic s_s;
  logic dly_q;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s_s = irq_i;
    end else begin : g_chain
      logic [SYNC_STAGES-1:0] chain_q;

      // Shift the raw source through the synchroniser flops.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          chain_q <= '0;
        end else begin
          chain_q[0] <= irq_i;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            chain_q[k] <= chain_q[k-1];
          end
        end
      end

      assign s_s = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  // Delay the synchronised level by one clock for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly_q <= 1'b0;
    end else begin
      dly_q <= s_s;
    end
  end

  assign s_o    = s_s;
  assign rise_o = s_s & ~dly_q;

endmodule

// File: rtl/host_irq_ctrl.sv
// host_irq_ctrl: synchronises, latches, masks and priority-encodes up to 16
// interrupt sources onto one registered irq_out.
// Optional feature: define HOST_IRQ_CTRL_HOLDOFF_EN to add the HOLDOFF register
// and a down-counter that keeps irq_out low for HOLDOFF clocks after it drops.
module host_irq_ctrl
  import host_irq_ctrl_pkg::*;
#(
  parameter int                NUM_SRC     = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_MASK  = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  host_irq_ctrl_if.slave     bus,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq_out
);

  logic [NUM_SRC-1:0] s_s, rise_s;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               irq_q, irq_d;

  logic               wr_s;
  logic [NUM_SRC-1:0] wdata_s, w1c_s, force_s;
  logic [DATA_W-1:0]  pend16_s, mask16_s, edge16_s, act16_s, holdoff_rd_s;
  logic               raw_irq_s;
  prio_t              prio_s;
  logic               unused_s;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    host_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .irq_i  (irq_in[g]),
      .s_o    (s_s[g]),
      .rise_o (rise_s[g])
    );
  end

  assign wr_s      = bus.chipselect & ~bus.write_n;
  assign wdata_s   = bus.writedata[NUM_SRC-1:0];
  assign w1c_s     = (wr_s && bus.address == ADDR_PENDING) ? wdata_s : '0;
  assign force_s   = (wr_s && bus.address == ADDR_FORCE)   ? wdata_s : '0;
  assign raw_irq_s = |(pending_q & mask_q);
  assign unused_s  = ^bus.writedata;

  // Next state of PENDING/MASK/EDGE: a set event beats W1C, level sources follow s.
  always_comb begin
    pending_d = pending_q;
    mask_d    = (wr_s && bus.address == ADDR_MASK) ? wdata_s : mask_q;
    edge_d    = (wr_s && bus.address == ADDR_EDGE) ? wdata_s : edge_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_q[i]) begin
        if (rise_s[i] | force_s[i]) begin
          pending_d[i] = 1'b1;
        end else if (w1c_s[i]) begin
          pending_d[i] = 1'b0;
        end else begin
          pending_d[i] = pending_q[i];
        end
      end else begin
        pending_d[i] = s_s[i] | force_s[i];
      end
    end
  end

  // Zero-extend the per-source registers and select the read word.
  always_comb begin
    pend16_s = '0;
    mask16_s = '0;
    edge16_s = '0;
    act16_s  = '0;
    pend16_s[NUM_SRC-1:0] = pending_q;
    mask16_s[NUM_SRC-1:0] = mask_q;
    edge16_s[NUM_SRC-1:0] = edge_q;
    act16_s[NUM_SRC-1:0]  = pending_q & mask_q;
    prio_s = prio_encode(act16_s);
    case (bus.address)
      ADDR_PENDING: rdata_d = pend16_s;
      ADDR_MASK:    rdata_d = mask16_s;
      ADDR_EDGE:    rdata_d = edge16_s;
      ADDR_ACTIVE:  rdata_d = act16_s;
      ADDR_VECTOR:  rdata_d = {prio_s.valid, 11'b0, prio_s.idx};
      ADDR_HOLDOFF: rdata_d = holdoff_rd_s;
      default:      rdata_d = 16'h0000;
    endcase
  end

`ifdef HOST_IRQ_CTRL_HOLDOFF_EN
  logic [DATA_W-1:0] holdoff_q, holdoff_d, cnt_q, cnt_d, cnt_dec_s;

  // Holdoff: load on irq_out falling, gate irq_out until the count drains.
  always_comb begin
    holdoff_d = (wr_s && bus.address == ADDR_HOLDOFF) ? bus.writedata : holdoff_q;
    if (cnt_q != 16'd0) begin
      cnt_dec_s = cnt_q - 16'd1;
    end else begin
      cnt_dec_s = 16'd0;
    end
    if (irq_q && !raw_irq_s) begin
      cnt_d = holdoff_q;
    end else begin
      cnt_d = cnt_dec_s;
    end
    irq_d        = raw_irq_s & (cnt_dec_s == 16'd0);
    holdoff_rd_s = holdoff_q;
  end

  // Holdoff register and countdown state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holdoff_q <= 16'h0000;
      cnt_q     <= 16'h0000;
    end else begin
      holdoff_q <= holdoff_d;
      cnt_q     <= cnt_d;
    end
  end
`else
  assign irq_d        = raw_irq_s;
  assign holdoff_rd_s = 16'h0000;
`endif

  // Register file, registered read data and registered interrupt output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      mask_q    <= RESET_MASK[NUM_SRC-1:0];
      edge_q    <= '0;
      rdata_q   <= 16'h0000;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq_out      = irq_q;

endmodule

// File: tb/tb_host_irq_ctrl.sv
// tb_host_irq_ctrl: table-driven register checks, hand-written timing
// sequences and a randomized run against a delay-line reference model.
module tb_host_irq_ctrl;
  localparam int N = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic         irq_out;
  int           checks = 0;
  int           errors = 0;

  host_irq_ctrl_if bus();

  host_irq_ctrl #(.NUM_SRC(N), .SYNC_STAGES(S), .RESET_MASK(16'h0000)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .irq_in (irq_in),
    .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] irq;
    logic         wr;
    logic [2:0]   addr;
    logic [15:0]  wdata;
    logic         chk;
    logic [15:0]  exp;
    string        nm;
  } vec_t;
  vec_t tbl[$];

  // reference model state
  logic [N-1:0] m_pend, m_mask, m_edge;
  logic [N-1:0] hist[0:S+1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus.address = a;
    tick();
    d = bus.readdata;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; irq_in = '0;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 3'd0; bus.writedata = 16'h0000;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic add(input logic [N-1:0] irq, input logic w, input logic [2:0] a,
                     input logic [15:0] d, input logic c, input logic [15:0] e, input string nm);
    vec_t v;
    v.irq = irq; v.wr = w; v.addr = a; v.wdata = d; v.chk = c; v.exp = e; v.nm = nm;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rv, rd_exp, vexp;
    logic        irq_exp;
    logic [N-1:0] sv, dv, act, f, c;
    logic        w;
    int          low;

    // ---- reset values, both during and after reset ----
    do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_readdata", bus.readdata, 16'h0000);
    chk("rst_irq", {15'b0, irq_out}, 16'h0000);
    reset_n = 1'b1;
    tick();

    // ---- table-driven register checks ----
    for (int a = 0; a < 8; a++) add('0, 1'b0, 3'(a), 16'h0, 1'b1, 16'h0000, "rst_reg");
    add(8'h24, 1'b1, 3'd1, 16'h0024, 1'b0, 16'h0, "");
    for (int k = 0; k < 3; k++) add(8'h24, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, "");
    add(8'h24, 1'b0, 3'd0, 16'h0, 1'b1, 16'h0024, "pend_level");
    add(8'h24, 1'b0, 3'd3, 16'h0, 1'b1, 16'h0024, "active");
    add(8'h24, 1'b0, 3'd4, 16'h0, 1'b1, 16'h8002, "vector_2");
    add(8'h24, 1'b1, 3'd1, 16'h0020, 1'b0, 16'h0, "");
    add(8'h24, 1'b0, 3'd4, 16'h0, 1'b1, 16'h8005, "vector_5");
    add(8'h24, 1'b1, 3'd1, 16'h0000, 1'b0, 16'h0, "");
    add(8'h24, 1'b0, 3'd4, 16'h0, 1'b1, 16'h0000, "vector_none");
    add(8'h24, 1'b0, 3'd3, 16'h0, 1'b1, 16'h0000, "active_none");
    add(8'h24, 1'b1, 3'd1, 16'hFFFF, 1'b0, 16'h0, "");
    add(8'h24, 1'b0, 3'd1, 16'h0, 1'b1, 16'h00FF, "mask_upper_zero");
    add(8'h24, 1'b1, 3'd2, 16'hFFFF, 1'b0, 16'h0, "");
    add(8'h24, 1'b0, 3'd2, 16'h0, 1'b1, 16'h00FF, "edge_upper_zero");
    add(8'h24, 1'b1, 3'd0, 16'h0024, 1'b0, 16'h0, "");
    add(8'h24, 1'b0, 3'd0, 16'h0, 1'b1, 16'h0000, "edge_on_high_no_set");
    add(8'h24, 1'b1, 3'd7, 16'hFFFF, 1'b0, 16'h0, "");
    add(8'h24, 1'b0, 3'd7, 16'h0, 1'b1, 16'h0000, "reserved_zero");
    foreach (tbl[i]) begin
      irq_in = tbl[i].irq; bus.address = tbl[i].addr; bus.writedata = tbl[i].wdata;
      bus.chipselect = tbl[i].wr; bus.write_n = ~tbl[i].wr;
      tick();
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
      if (tbl[i].chk) chk(tbl[i].nm, bus.readdata, tbl[i].exp);
    end

    // ---- edge source 0: pulse latency, then W1C ----
    do_reset();
    wr(3'd2, 16'h0001); wr(3'd1, 16'h0001);
    irq_in = 8'h01; tick(); irq_in = 8'h00;
    repeat (2) tick();
    chk("edge_lat_3", {15'b0, irq_out}, 16'h0000);
    tick();
    chk("edge_lat_4", {15'b0, irq_out}, 16'h0001);
    rd(3'd0, rv); chk("edge_pend", rv, 16'h0001);
    wr(3'd0, 16'h0001);
    chk("w1c_lat_1", {15'b0, irq_out}, 16'h0001);
    tick();
    chk("w1c_lat_2", {15'b0, irq_out}, 16'h0000);

    // ---- level source 3: W1C has no lasting effect ----
    wr(3'd2, 16'h0000); wr(3'd1, 16'h0008);
    irq_in = 8'h08;
    repeat (6) tick();
    chk("level_irq", {15'b0, irq_out}, 16'h0001);
    wr(3'd0, 16'h0008);
    for (int k = 0; k < 3; k++) begin tick(); chk("level_w1c_hold", {15'b0, irq_out}, 16'h0001); end
    irq_in = 8'h00;
    repeat (3) tick();
    chk("level_drop_3", {15'b0, irq_out}, 16'h0001);
    tick();
    chk("level_drop_4", {15'b0, irq_out}, 16'h0000);

    // ---- reset mid-operation ----
    irq_in = 8'h08;
    repeat (6) tick();
    rd(3'd1, rv);
    chk("pre_reset_mask", rv, 16'h0008);
    reset_n = 1'b0;
    #2;
    chk("midrst_readdata", bus.readdata, 16'h0000);
    chk("midrst_irq", {15'b0, irq_out}, 16'h0000);
    reset_n = 1'b1; irq_in = 8'h00;
    tick();
    rd(3'd1, rv); chk("midrst_mask", rv, 16'h0000);

    // ---- set beats W1C in the same clock; FORCE ----
    do_reset();
    wr(3'd2, 16'h0012); wr(3'd1, 16'h0012);
    wr(3'd6, 16'h0002);
    rd(3'd0, rv); chk("force_edge1", rv, 16'h0002);
    irq_in = 8'h02; tick(); tick();
    wr(3'd0, 16'h0002);
    rd(3'd0, rv); chk("set_beats_w1c", rv, 16'h0002);
    wr(3'd0, 16'h0002);
    rd(3'd0, rv); chk("w1c_clears", rv, 16'h0000);
    wr(3'd6, 16'h0010);
    rd(3'd0, rv); chk("force_edge4", rv, 16'h0010);
    wr(3'd6, 16'h0004);
    rd(3'd0, rv); chk("force_level_pulse", rv, 16'h0014);
    rd(3'd0, rv); chk("force_level_gone", rv, 16'h0010);
    rd(3'd6, rv); chk("force_reads_zero", rv, 16'h0000);

    // ---- randomized run against the reference model ----
    do_reset();
    m_pend = '0; m_mask = '0; m_edge = '0;
    for (int j = 0; j <= S + 1; j++) hist[j] = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      irq_in = irq_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
      bus.address    = 3'($urandom_range(0, 7));
      bus.writedata  = 16'($urandom);
      bus.chipselect = 1'($urandom_range(0, 1));
      bus.write_n    = (bus.address == 3'd5) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = irq_in;
      sv = hist[S]; dv = hist[S+1];
      act = m_pend & m_mask;
      vexp = 16'h0000;
      for (int b = N - 1; b >= 0; b--) if (act[b]) vexp = 16'h8000 | 16'(b);
      case (bus.address)
        3'd0: rd_exp = 16'(m_pend);
        3'd1: rd_exp = 16'(m_mask);
        3'd2: rd_exp = 16'(m_edge);
        3'd3: rd_exp = 16'(act);
        3'd4: rd_exp = vexp;
        default: rd_exp = 16'h0000;
      endcase
      irq_exp = |act;
      w = bus.chipselect & ~bus.write_n;
      f = (w && bus.address == 3'd6) ? bus.writedata[N-1:0] : '0;
      c = (w && bus.address == 3'd0) ? bus.writedata[N-1:0] : '0;
      for (int b = 0; b < N; b++) begin
        if (m_edge[b]) begin
          if ((sv[b] & ~dv[b]) | f[b]) m_pend[b] = 1'b1;
          else if (c[b]) m_pend[b] = 1'b0;
        end else begin
          m_pend[b] = sv[b] | f[b];
        end
      end
      if (w && bus.address == 3'd1) m_mask = bus.writedata[N-1:0];
      if (w && bus.address == 3'd2) m_edge = bus.writedata[N-1:0];
      tick();
      chk("rand_readdata", bus.readdata, rd_exp);
      chk("rand_irq", {15'b0, irq_out}, {15'b0, irq_exp});
    end
    bus.chipselect = 1'b0; bus.write_n = 1'b1;

`ifdef HOST_IRQ_CTRL_HOLDOFF_EN
    // ---- holdoff: irq_out low exactly HOLDOFF clocks ----
    do_reset();
    wr(3'd5, 16'd10);
    rd(3'd5, rv); chk("holdoff_reg", rv, 16'd10);
    wr(3'd2, 16'h0001); wr(3'd1, 16'h0001); wr(3'd6, 16'h0001);
    repeat (3) tick();
    chk("holdoff_pre_irq", {15'b0, irq_out}, 16'h0001);
    wr(3'd0, 16'h0001);
    wr(3'd6, 16'h0001);
    low = 0;
    for (int t = 0; t < 40 && !irq_out; t++) begin
      low++;
      tick();
    end
    chk("holdoff_low_cycles", 16'(low), 16'd10);
    chk("holdoff_irq_back", {15'b0, irq_out}, 16'h0001);
`else
    do_reset();
    wr(3'd5, 16'h1234);
    rd(3'd5, rv); chk("holdoff_absent", rv, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
